capture_ctrl: RTL and testbench

- Sequences one acquisition into the circular sample RAM that the protocol trigger units (SPI/UART/edge) gate.
- After run: fills the pre-trigger window, arms, waits for the OR-ed trigger pulse, captures trig_pos post-trigger samples, then halts with capture_done.
- Generates the RAM write enable and address.
- Reports the trigger address so readback can unroll the circular buffer.

---
 rtl/capture_pkg.sv | 12 +
 rtl/capture_ctrl.sv | 123 ++++++++++++
 tb/tb_capture_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the acquisition sequencer.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DONE  = 3'd4
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl.sv
// Acquisition sequencer for the circular sample RAM: pre-fill, arm, trigger,
// post-trigger capture, then halt with the trigger address for readback.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              abort,
    input  logic              smpl_en,
    input  logic              trig,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              armed,
    output logic              triggered,
    output logic              capture_done,
    output logic              busy
);

    localparam int unsigned ENTRIES = 2 ** ADDR_W;
    localparam int unsigned CNT_W   = ADDR_W + 1;

    cap_state_t        state_q;
    cap_state_t        state_d;
    logic [CNT_W-1:0]  pre_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] trig_pos_q;
    logic [CNT_W-1:0]  pre_target;
    logic              pre_hit;
    logic              post_hit;
    logic              restart;
    logic              trig_accept;

    // Pre-fill length is ENTRIES - trig_pos so the window holds a full buffer.
    assign pre_target  = CNT_W'(ENTRIES) - {1'b0, trig_pos_q};
    assign pre_hit     = (pre_cnt + CNT_W'(1)) == pre_target;
    assign post_hit    = post_cnt == (trig_pos_q - ADDR_W'(1));
    assign restart     = run && !abort;
    assign trig_accept = (state_q == ARMED) && trig && !run && !abort;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides run, both override the sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            PRE:     if (smpl_en && pre_hit) state_d = ARMED;
            ARMED:   if (trig) state_d = (trig_pos_q == '0) ? DONE : POST;
            POST:    if (smpl_en && post_hit) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (run)   state_d = PRE;
        if (abort) state_d = IDLE;
    end

    // Combinational outputs decoded from the registered state
    always_comb begin
        busy = 1'b0;
        we   = 1'b0;
        if (state_q == PRE || state_q == ARMED || state_q == POST) begin
            busy = 1'b1;
        end
        we = smpl_en && busy;
    end

    // Address, counters and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr        <= '0;
            trig_addr    <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            trig_pos_q   <= '0;
            armed        <= 1'b0;
            triggered    <= 1'b0;
            capture_done <= 1'b0;
        end else begin
            armed        <= (state_d == ARMED);
            capture_done <= (state_d == DONE);
            if (restart) begin
                waddr      <= '0;
                pre_cnt    <= '0;
                post_cnt   <= '0;
                trig_pos_q <= trig_pos;
            end else begin
                if (we) begin
                    waddr <= waddr + ADDR_W'(1);
                end
                if (state_q == PRE && we) begin
                    pre_cnt <= pre_cnt + CNT_W'(1);
                end
                if (trig_accept) begin
                    post_cnt <= '0;
                end else if (state_q == POST && we) begin
                    post_cnt <= post_cnt + ADDR_W'(1);
                end
                // A sample strobed with the trigger belongs to the pre-trigger window
                if (trig_accept) begin
                    trig_addr <= smpl_en ? waddr + ADDR_W'(1) : waddr;
                end
            end
            if (run || abort) begin
                triggered <= 1'b0;
            end else if (trig_accept) begin
                triggered <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a 16-entry buffer.
module tb_capture_ctrl;

    localparam int unsigned ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              abort;
    logic              smpl_en;
    logic              trig;
    logic [ADDR_W-1:0] trig_pos;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic          we_s;
    logic [ADDR_W-1:0] addr_s;

    capture_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .abort        (abort),
        .smpl_en      (smpl_en),
        .trig         (trig),
        .trig_pos     (trig_pos),
        .we           (we),
        .waddr        (waddr),
        .trig_addr    (trig_addr),
        .armed        (armed),
        .triggered    (triggered),
        .capture_done (capture_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock cycle with the given inputs; reports we/waddr seen before the edge
    task automatic tick(input logic r, input logic a, input logic s, input logic t,
                        output logic we_o, output logic [ADDR_W-1:0] addr_o);
        run = r; abort = a; smpl_en = s; trig = t;
        #1;
        we_o   = we;
        addr_o = waddr;
        @(posedge clk);
        #1;
        run = 1'b0; abort = 1'b0; smpl_en = 1'b0; trig = 1'b0;
    endtask

    task automatic writes(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; abort = 1'b0; smpl_en = 1'b0; trig = 1'b0;
        trig_pos = '0;
        #3;
        chk("rst_waddr", int'(waddr), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(capture_done), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("idle_we", int'(we_s), 0);

        // 1: normal capture, trig_pos=4
        trig_pos = 4'd4;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        chk("t1_busy", int'(busy), 1);
        writes(5);
        tick(1'b0, 1'b0, 1'b0, 1'b1, we_s, addr_s);
        chk("t1_early_trig", int'(triggered), 0);
        writes(6);
        chk("t1_not_armed11", int'(armed), 0);
        writes(1);
        chk("t1_armed", int'(armed), 1);
        chk("t1_armed_waddr", int'(waddr), 12);
        writes(2);
        tick(1'b0, 1'b0, 1'b0, 1'b1, we_s, addr_s);
        chk("t1_triggered", int'(triggered), 1);
        chk("t1_armed_clr", int'(armed), 0);
        chk("t1_trig_addr", int'(trig_addr), 14);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
            chk("t1_post_we", int'(we_s), 1);
            chk("t1_post_addr", int'(addr_s), (14 + i) % 16);
        end
        chk("t1_done", int'(capture_done), 1);
        chk("t1_busy_off", int'(busy), 0);
        chk("t1_final_waddr", int'(waddr), 2);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t1_done_no_we", int'(we_s), 0);
        chk("t1_waddr_hold", int'(waddr), 2);

        // 2: trig_pos=0, full-buffer pre-fill
        trig_pos = 4'd0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        chk("t2_done_clr", int'(capture_done), 0);
        writes(15);
        chk("t2_not_armed15", int'(armed), 0);
        writes(1);
        chk("t2_armed", int'(armed), 1);
        chk("t2_wrap", int'(waddr), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, we_s, addr_s);
        chk("t2_done", int'(capture_done), 1);
        chk("t2_triggered", int'(triggered), 1);
        chk("t2_trig_addr", int'(trig_addr), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t2_no_we", int'(we_s), 0);

        // 3: trigger coincident with a sample, trig_pos=2
        trig_pos = 4'd2;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        writes(29);
        chk("t3_armed", int'(armed), 1);
        chk("t3_waddr", int'(waddr), 13);
        tick(1'b0, 1'b0, 1'b1, 1'b1, we_s, addr_s);
        chk("t3_trig_we", int'(we_s), 1);
        chk("t3_trig_waddr", int'(addr_s), 13);
        chk("t3_trig_addr", int'(trig_addr), 14);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t3_post0", int'(addr_s), 14);
        chk("t3_not_done", int'(capture_done), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t3_post1", int'(addr_s), 15);
        chk("t3_done", int'(capture_done), 1);

        // 4: abort during POST
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        writes(14);
        tick(1'b0, 1'b0, 1'b0, 1'b1, we_s, addr_s);
        writes(1);
        chk("t4_in_post", int'(busy), 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0, we_s, addr_s);
        chk("t4_busy", int'(busy), 0);
        chk("t4_done", int'(capture_done), 0);
        chk("t4_triggered", int'(triggered), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t4_no_we", int'(we_s), 0);

        // 5: restart while armed with a new trig_pos, then run+abort
        trig_pos = 4'd4;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        writes(12);
        chk("t5_armed", int'(armed), 1);
        trig_pos = 4'd8;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        chk("t5_waddr0", int'(waddr), 0);
        chk("t5_armed_clr", int'(armed), 0);
        chk("t5_busy", int'(busy), 1);
        writes(7);
        chk("t5_not_armed7", int'(armed), 0);
        writes(1);
        chk("t5_armed8", int'(armed), 1);
        chk("t5_waddr8", int'(waddr), 8);
        tick(1'b1, 1'b1, 1'b0, 1'b0, we_s, addr_s);
        chk("t5_abort_wins", int'(busy), 0);
        chk("t5_abort_armed", int'(armed), 0);

        // 6: asynchronous reset during POST
        trig_pos = 4'd4;
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        writes(12);
        tick(1'b0, 1'b0, 1'b0, 1'b1, we_s, addr_s);
        writes(1);
        smpl_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_we", int'(we), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_waddr", int'(waddr), 0);
        chk("t6_trig_addr", int'(trig_addr), 0);
        chk("t6_triggered", int'(triggered), 0);
        smpl_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t6_idle_we", int'(we_s), 0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, we_s, addr_s);
        tick(1'b0, 1'b0, 1'b1, 1'b0, we_s, addr_s);
        chk("t6_run_we", int'(we_s), 1);
        chk("t6_run_addr", int'(addr_s), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
